des_rd_responder: RTL and testbench
===================================

# des_rd_responder

Read-side responder for the DES read-only worker pipeline. It accepts one read request at a time: start address, word size, length in words minus one, and an attached task/subtype/CQ slot. It fetches the touched 64-byte lines over a single-outstanding line-read port. It returns one response task per word, carrying `word_id` and an optional last mark, back to the worker stage that issued the request.

## Interface
Parameters
- `TILE_ID`, 0, tile index; used only for simulation logging.
- `LINE_BYTES`, 64, memory line size; fixed at 64 in this revision.

Ports
- `clk`  in  1  clock
- `rstn`  in  1  reset; asynchronous, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  block idle, request accepted this cycle if `req_valid`
- `req_addr`  in  32  byte address of first word
- `req_size`  in  3  log2 word bytes; 2 selects 4 B, any other value selects 8 B
- `req_len`  in  8  word count minus one
- `req_task`  in  task_t  task copied to every response
- `req_subtype`  in  subtype_t  subtype copied to every response
- `req_mark_last`  in  1  flag the final response as last
- `req_cq_slot`  in  cq_slice_slot_t  CQ slot copied to every response
- `mem_arvalid`  out  1  line read request
- `mem_arready`  in  1  line read accepted
- `mem_araddr`  out  32  line address, `[5:0]` = 0
- `mem_rvalid`  in  1  line data valid
- `mem_rready`  out  1  line data accepted
- `mem_rdata`  in  512  line data; byte k at bits `[8k+7:8k]`
- `resp_valid`  out  1  response word valid
- `resp_ready`  in  1  consumer accepts word
- `resp_task`  out  task_t  latched `req_task`
- `resp_subtype`  out  subtype_t  latched `req_subtype`
- `resp_cq_slot`  out  cq_slice_slot_t  latched `req_cq_slot`
- `resp_data`  out  data_t (64)  word; 4 B words are zero-extended
- `resp_word_id`  out  8  index of word within request, 0..`req_len`
- `resp_last`  out  1  `req_mark_last` & (`resp_word_id` == latched len)

## Operation
- States: IDLE, AR, R, EMIT.
- IDLE
  - `req_ready`=1.
  - On `req_valid`, latch all request fields, set `cur_addr`=`req_addr` and `word_id`=0, then go to AR.
- AR
  - `mem_arvalid`=1 and `mem_araddr`={`cur_addr[31:6]`,6'b0}.
  - Address is held stable until `mem_arready`; on handshake go to R.
- R
  - `mem_rready`=1.
  - On `mem_rvalid`, capture `mem_rdata` into the line buffer and go to EMIT.
  - Exactly one beat per line read.
- EMIT
  - `resp_valid`=1.
  - Word extraction:
    - size 8 B: `resp_data`=`line[64*cur_addr[5:3] +: 64]`.
    - size 4 B: `resp_data`={32'b0, `line[32*cur_addr[5:2] +: 32]`}.
  - Address low bits below the word size are ignored.
  - On `resp_ready`:
    - If `word_id`==len, go to IDLE.
    - Otherwise, `word_id`++ and `cur_addr`+=word bytes. If the new `cur_addr[31:6]` differs from the old, go to AR; otherwise stay in EMIT.
- Arithmetic
  - `cur_addr` is 32-bit, wrapping at 2^32.
  - `word_id` never exceeds len, so it never wraps.
- All `resp_*` payload outputs hold stable while `resp_valid`=1 and `resp_ready`=0.
- Reset values:
  - `req_ready`=0 during reset, 1 in the first cycle after release (IDLE).
  - `mem_arvalid`=0, `mem_araddr`=0, `mem_rready`=0.
  - `resp_valid`=0, `resp_last`=0, `resp_word_id`=0, `resp_data`=0.
- Reset asserted mid-request aborts the request immediately. The memory port is reset together with this block, so a stale R beat is never delivered.
- `mem_rvalid` outside R is a protocol error: ignored, and flagged under XILINX_SIMULATOR.

## Timing
- Request accepted at cycle t gives `mem_arvalid` at t+1.
- `mem_rvalid` accepted at cycle r gives `resp_valid` with word 0 of that line at r+1.
- Words within one line stream at 1 per cycle while `resp_ready`=1.
- A line crossing costs at least 2 cycles: 1 in AR plus 1 in R at minimum memory latency.
- Final word handshake at cycle e gives `req_ready`=1 at e+1.
- `mem_arvalid` and `resp_valid` never deassert without a handshake.
- Outputs are registered or decoded from state only; there is no combinational path from `resp_ready` or `mem_arready` to any valid.

## Test plan
- Single 8 B word:
  - Stimulus: size=3, len=0, addr=0x1008, `req_mark_last`=1; memory returns a line with bytes 8..15 = 0x00000005_00000002.
  - Required: one AR at 0x1000; one response with data 0x0000000500000002, `word_id`=0, `resp_last`=1.
- Line-crossing 4 B burst:
  - Stimulus: size=2, len=3, addr=0x2038.
  - Required: AR 0x2000, words from 0x2038 and 0x203C; then AR 0x2040, words from 0x2040 and 0x2044; `word_id` 0,1,2,3 in order; `resp_last` only on word 3.
- Backpressure:
  - Stimulus: 8-word burst with `resp_ready` held low for 5 cycles after word 2.
  - Required: word 2 payload stable throughout; no words skipped or duplicated; `req_ready` stays 0.
- No last mark and AR stall:
  - Stimulus: `req_mark_last`=0, len=7; `mem_arready` held low for 4 cycles.
  - Required: `mem_araddr` stable throughout the stall; `resp_last` never asserted; 8 responses delivered.
- Reset mid-EMIT:
  - Stimulus: assert `rstn`=0 after word 1 of a 4-word request, then release.
  - Required: all outputs at reset values asynchronously; `req_ready`=1 after release; the next request completes normally with `word_id` starting at 0.

Source files
------------

// File: rtl/des_rd_responder_if.sv
// Shared types and the bus bundle for des_rd_responder.
// des_rd_pkg     : payload types carried from request to every response word.
// des_rd_responder_if groups three handshakes:
//   req_*  : one read request (address, word size, length-1, task/subtype/CQ slot)
//   mem_*  : single-outstanding 64-byte line read (AR address, R data beat)
//   resp_* : one response word per cycle back to the issuing worker
// Modport slave is the responder's view; master is the view of the
// environment that issues requests, serves lines and consumes words.
package des_rd_pkg;
   typedef logic [15:0] task_t;
   typedef logic [3:0]  subtype_t;
   typedef logic [5:0]  cq_slice_slot_t;
   typedef logic [63:0] data_t;
endpackage

interface des_rd_responder_if;
   import des_rd_pkg::*;

   logic           req_valid;
   logic           req_ready;
   logic [31:0]    req_addr;
   logic [2:0]     req_size;
   logic [7:0]     req_len;
   task_t          req_task;
   subtype_t       req_subtype;
   logic           req_mark_last;
   cq_slice_slot_t req_cq_slot;

   logic           mem_arvalid;
   logic           mem_arready;
   logic [31:0]    mem_araddr;
   logic           mem_rvalid;
   logic           mem_rready;
   logic [511:0]   mem_rdata;

   logic           resp_valid;
   logic           resp_ready;
   task_t          resp_task;
   subtype_t       resp_subtype;
   cq_slice_slot_t resp_cq_slot;
   data_t          resp_data;
   logic [7:0]     resp_word_id;
   logic           resp_last;

   modport slave (
      input  req_valid, req_addr, req_size, req_len, req_task, req_subtype,
             req_mark_last, req_cq_slot,
      output req_ready,
      output mem_arvalid, mem_araddr, mem_rready,
      input  mem_arready, mem_rvalid, mem_rdata,
      output resp_valid, resp_task, resp_subtype, resp_cq_slot, resp_data,
             resp_word_id, resp_last,
      input  resp_ready
   );

   modport master (
      output req_valid, req_addr, req_size, req_len, req_task, req_subtype,
             req_mark_last, req_cq_slot,
      input  req_ready,
      input  mem_arvalid, mem_araddr, mem_rready,
      output mem_arready, mem_rvalid, mem_rdata,
      input  resp_valid, resp_task, resp_subtype, resp_cq_slot, resp_data,
             resp_word_id, resp_last,
      output resp_ready
   );
endinterface

// File: rtl/des_rd_responder.sv
// des_rd_responder: read-side responder of the DES read-only worker pipeline.
// Accepts one request at a time, fetches each touched 64-byte line over a
// single-outstanding line-read port, and returns one response per word with
// word_id and an optional last mark.
// Ports:
//   clk  - clock
//   rstn - asynchronous active-low reset
//   bus  - des_rd_responder_if.slave (req_*, mem_*, resp_* handshakes)
module des_rd_responder
   import des_rd_pkg::*;
#(
   parameter int TILE_ID    = 0,
   parameter int LINE_BYTES = 64
) (
   input  logic                      clk,
   input  logic                      rstn,
   des_rd_responder_if.slave         bus
);

   localparam int OFS = $clog2(LINE_BYTES);

   typedef enum logic [1:0] {IDLE, AR, R, EMIT} state_t;

   state_t       state;
   logic [31:0]  cur_addr;
   logic [511:0] line;
   logic [7:0]   len;
   logic         size8;
   logic         mark_last;

   logic [31:0]  nxt_addr;
   logic [7:0]   nxt_id;
   logic         last_word;

   // Pick the word addressed by wsel (= addr[5:2]) out of a line; address
   // bits below the word size are dropped, 4 B words are zero-extended.
   function automatic data_t extract(input logic [511:0] l, input logic [3:0] wsel,
                                     input logic s8);
      if (s8) return l[64*wsel[3:1] +: 64];
      return {32'b0, l[32*wsel +: 32]};
   endfunction

   assign nxt_addr  = cur_addr + (size8 ? 32'd8 : 32'd4);
   assign nxt_id    = bus.resp_word_id + 8'd1;
   assign last_word = (bus.resp_word_id == len);

   // Decoded from state; gated by rstn so it reads 0 while reset is held.
   assign bus.req_ready = rstn && (state == IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state            <= IDLE;
         cur_addr         <= '0;
         line             <= '0;
         len              <= '0;
         size8            <= 1'b0;
         mark_last        <= 1'b0;
         bus.mem_arvalid  <= 1'b0;
         bus.mem_araddr   <= '0;
         bus.mem_rready   <= 1'b0;
         bus.resp_valid   <= 1'b0;
         bus.resp_task    <= '0;
         bus.resp_subtype <= '0;
         bus.resp_cq_slot <= '0;
         bus.resp_data    <= '0;
         bus.resp_word_id <= '0;
         bus.resp_last    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  cur_addr         <= bus.req_addr;
                  len              <= bus.req_len;
                  size8            <= (bus.req_size != 3'd2);
                  mark_last        <= bus.req_mark_last;
                  bus.resp_task    <= bus.req_task;
                  bus.resp_subtype <= bus.req_subtype;
                  bus.resp_cq_slot <= bus.req_cq_slot;
                  bus.resp_word_id <= '0;
                  bus.mem_arvalid  <= 1'b1;
                  bus.mem_araddr   <= {bus.req_addr[31:OFS], {OFS{1'b0}}};
                  state            <= AR;
               end
            end
            AR: begin
               if (bus.mem_arready) begin
                  bus.mem_arvalid <= 1'b0;
                  bus.mem_rready  <= 1'b1;
                  state           <= R;
               end
            end
            R: begin
               // Word is extracted straight from the beat so it is valid the
               // cycle after the R handshake.
               if (bus.mem_rvalid) begin
                  line           <= bus.mem_rdata;
                  bus.mem_rready <= 1'b0;
                  bus.resp_valid <= 1'b1;
                  bus.resp_data  <= extract(bus.mem_rdata, cur_addr[5:2], size8);
                  bus.resp_last  <= mark_last && last_word;
                  state          <= EMIT;
               end
            end
            EMIT: begin
               if (bus.resp_ready) begin
                  if (last_word) begin
                     bus.resp_valid <= 1'b0;
                     bus.resp_last  <= 1'b0;
                     state          <= IDLE;
                  end else begin
                     cur_addr         <= nxt_addr;
                     bus.resp_word_id <= nxt_id;
                     bus.resp_last    <= mark_last && (nxt_id == len);
                     if (nxt_addr[31:OFS] != cur_addr[31:OFS]) begin
                        // Next word lives in another line (incl. 2^32 wrap).
                        bus.resp_valid  <= 1'b0;
                        bus.mem_arvalid <= 1'b1;
                        bus.mem_araddr  <= {nxt_addr[31:OFS], {OFS{1'b0}}};
                        state           <= AR;
                     end else begin
                        bus.resp_data <= extract(line, nxt_addr[5:2], size8);
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef XILINX_SIMULATOR
   // A data beat outside R is a memory-side protocol error; it is ignored.
   always @(posedge clk)
      if (rstn && bus.mem_rvalid && state != R)
         $error("des_rd_responder[%0d]: mem_rvalid outside R", TILE_ID);
`endif

endmodule

// File: tb/tb_des_rd_responder.sv
module tb_des_rd_responder;
   import des_rd_pkg::*;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   des_rd_responder_if bus();

   des_rd_responder #(.TILE_ID(0), .LINE_BYTES(64)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int checks = 0;
   int failures = 0;

   // memory model state
   logic [31:0] ar_q[$];
   int          ar_stall_cfg = 0;
   int          r_lat_cfg = 0;
   bit          mem_rand = 1'b0;
   int          ar_unstable = 0;
   int          m_wait_ar = 0;
   int          m_wait_r = 0;
   bit          m_pend = 1'b0;
   bit          m_ar_seen = 1'b0;
   logic [31:0] m_ar_addr = '0;
   logic [31:0] m_last_ar = '0;

   // observed responses
   logic [63:0]    obs_data[$];
   logic [7:0]     obs_id[$];
   logic           obs_last[$];
   task_t          obs_task[$];
   subtype_t       obs_sub[$];
   cq_slice_slot_t obs_cq[$];
   int             hold_viol;
   int             rr_viol;
   bit             timed_out;

   // reference model output
   logic [31:0] exp_ar_q[$];
   logic [63:0] exp_w[$];

   // Backing store: a fixed pattern everywhere, except 0x1008..0x100F which
   // hold the 8-byte word 0x00000005_00000002 (little endian).
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      logic [63:0] w;
      logic [2:0]  off;
      w = 64'h00000005_00000002;
      off = a[2:0];
      if (a >= 32'h1008 && a <= 32'h100F) return w[8*off +: 8];
      return (a[7:0] * 8'd13) ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
   endfunction

   // Word k of a request sits at addr + k*bytes (mod 2^32), aligned down to
   // the word size; a line fetch is expected whenever the line changes.
   function automatic void build_exp(input logic [31:0] a, input bit s8, input int ln);
      logic [31:0] ak, base, lk, prev;
      logic [63:0] d;
      int wb;
      wb = s8 ? 8 : 4;
      exp_ar_q.delete();
      exp_w.delete();
      prev = '0;
      for (int k = 0; k <= ln; k++) begin
         ak = a + 32'(k * wb);
         lk = ak & 32'hFFFF_FFC0;
         if (k == 0 || lk != prev) exp_ar_q.push_back(lk);
         prev = lk;
         base = s8 ? (ak & 32'hFFFF_FFF8) : (ak & 32'hFFFF_FFFC);
         d = '0;
         for (int b = 0; b < wb; b++) d[8*b +: 8] = mem_byte(base + 32'(b));
         exp_w.push_back(d);
      end
   endfunction

   // Line-read server: one AR accept, then exactly one R beat per line.
   initial begin
      bus.mem_arready = 1'b0;
      bus.mem_rvalid  = 1'b0;
      bus.mem_rdata   = '0;
      forever begin
         @(negedge clk);
         bus.mem_arready = 1'b0;
         bus.mem_rvalid  = 1'b0;
         if (!rstn) begin
            m_pend = 1'b0;
            m_ar_seen = 1'b0;
            continue;
         end
         if (bus.mem_arvalid && !m_pend) begin
            if (!m_ar_seen) begin
               m_ar_seen = 1'b1;
               m_last_ar = bus.mem_araddr;
               m_wait_ar = mem_rand ? int'($urandom_range(0, 3)) : ar_stall_cfg;
            end else if (bus.mem_araddr !== m_last_ar) begin
               ar_unstable++;
            end
            if (m_wait_ar > 0) m_wait_ar--;
            else begin
               bus.mem_arready = 1'b1;
               ar_q.push_back(bus.mem_araddr);
               m_ar_addr = bus.mem_araddr;
               m_pend = 1'b1;
               m_ar_seen = 1'b0;
               m_wait_r = mem_rand ? int'($urandom_range(0, 3)) : r_lat_cfg;
            end
         end else if (m_pend && bus.mem_rready) begin
            if (m_wait_r > 0) m_wait_r--;
            else begin
               for (int k = 0; k < 64; k++) bus.mem_rdata[8*k +: 8] = mem_byte(m_ar_addr + 32'(k));
               bus.mem_rvalid = 1'b1;
               m_pend = 1'b0;
            end
         end
      end
   end

   task automatic send_req(input logic [31:0] a, input logic [2:0] sz, input logic [7:0] ln,
                           input bit mk, input task_t tk, input subtype_t st,
                           input cq_slice_slot_t cq, output bit ok);
      int n;
      n = 0;
      ok = 1'b0;
      ar_q.delete();
      @(negedge clk);
      while (!bus.req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) return;
      bus.req_addr = a;
      bus.req_size = sz;
      bus.req_len = ln;
      bus.req_mark_last = mk;
      bus.req_task = tk;
      bus.req_subtype = st;
      bus.req_cq_slot = cq;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      ok = 1'b1;
   endtask

   // Consumes n words; optionally stalls resp_ready for stall_cyc cycles the
   // first time word stall_id is presented. Records stability and req_ready
   // violations for the calling test to judge.
   task automatic collect(input int n, input int stall_id, input int stall_cyc, input bit rnd);
      int cyc, stall;
      bit stalled, held;
      logic [63:0] s_data;
      logic [7:0] s_id;
      logic s_last;
      task_t s_task;
      cyc = 0; stall = 0; stalled = 0; held = 0;
      s_data = '0; s_id = '0; s_last = 0; s_task = '0;
      obs_data.delete(); obs_id.delete(); obs_last.delete();
      obs_task.delete(); obs_sub.delete(); obs_cq.delete();
      hold_viol = 0; rr_viol = 0; timed_out = 0;
      while (obs_id.size() < n) begin
         if (cyc >= 3000) begin
            timed_out = 1;
            break;
         end
         @(negedge clk);
         cyc++;
         if (bus.req_ready) rr_viol++;
         if (bus.resp_valid && held &&
             {bus.resp_data, bus.resp_word_id, bus.resp_last, bus.resp_task} !==
             {s_data, s_id, s_last, s_task}) hold_viol++;
         if (bus.resp_valid && !stalled && stall_cyc > 0 && int'(bus.resp_word_id) == stall_id) begin
            stalled = 1;
            stall = stall_cyc;
         end
         if (stall > 0) begin
            bus.resp_ready = 1'b0;
            stall--;
         end else begin
            bus.resp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         if (bus.resp_valid && bus.resp_ready) begin
            obs_data.push_back(bus.resp_data);
            obs_id.push_back(bus.resp_word_id);
            obs_last.push_back(bus.resp_last);
            obs_task.push_back(bus.resp_task);
            obs_sub.push_back(bus.resp_subtype);
            obs_cq.push_back(bus.resp_cq_slot);
            held = 0;
         end else if (bus.resp_valid) begin
            held = 1;
            s_data = bus.resp_data; s_id = bus.resp_word_id;
            s_last = bus.resp_last; s_task = bus.resp_task;
         end else begin
            held = 0;
         end
      end
      @(posedge clk);
      #1 bus.resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus.req_valid = 0; bus.req_addr = '0; bus.req_size = '0; bus.req_len = '0;
      bus.req_mark_last = 0; bus.req_task = '0; bus.req_subtype = '0; bus.req_cq_slot = '0;
      bus.resp_ready = 0;
      rstn = 1'b0;
      #12;
      checks++;
      if ({bus.req_ready, bus.mem_arvalid, bus.mem_rready, bus.resp_valid, bus.resp_last} !== 5'b0)
         begin failures++; $display("FAIL reset_ctrl: got %b want 00000", {bus.req_ready, bus.mem_arvalid, bus.mem_rready, bus.resp_valid, bus.resp_last}); end
      checks++;
      if ({bus.mem_araddr, bus.resp_word_id, bus.resp_data} !== '0)
         begin failures++; $display("FAIL reset_data: araddr %h id %h data %h want 0", bus.mem_araddr, bus.resp_word_id, bus.resp_data); end
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b want 1", bus.req_ready); end
   endtask

   task automatic test_single_word();
      bit ok;
      mem_rand = 0; ar_stall_cfg = 0; r_lat_cfg = 0;
      build_exp(32'h1008, 1, 0);
      send_req(32'h1008, 3'd3, 8'd0, 1, 16'hBEEF, 4'h3, 6'h11, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL single_accept: req_ready never high"); return; end
      @(negedge clk);
      checks++;
      if (bus.mem_arvalid !== 1'b1 || bus.mem_araddr !== 32'h1000)
         begin failures++; $display("FAIL single_ar_timing: arvalid %b addr %h want 1 00001000", bus.mem_arvalid, bus.mem_araddr); end
      collect(1, 0, 0, 0);
      checks++;
      if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL single_ready_after: got %b want 1", bus.req_ready); end
      checks++;
      if (timed_out || obs_id.size() != 1) begin failures++; $display("FAIL single_count: got %0d want 1", obs_id.size()); return; end
      checks++;
      if (ar_q.size() != 1 || ar_q[0] !== 32'h1000) begin failures++; $display("FAIL single_ar: n=%0d want 1 at 00001000", ar_q.size()); end
      checks++;
      if (obs_data[0] !== 64'h0000000500000002 || exp_w[0] !== 64'h0000000500000002)
         begin failures++; $display("FAIL single_data: got %h want 0000000500000002", obs_data[0]); end
      checks++;
      if (obs_id[0] !== 8'd0 || obs_last[0] !== 1'b1 || obs_task[0] !== 16'hBEEF || obs_sub[0] !== 4'h3 || obs_cq[0] !== 6'h11)
         begin failures++; $display("FAIL single_meta: id %h last %b task %h sub %h cq %h", obs_id[0], obs_last[0], obs_task[0], obs_sub[0], obs_cq[0]); end
   endtask

   task automatic test_line_cross();
      bit ok;
      mem_rand = 0; ar_stall_cfg = 0; r_lat_cfg = 1;
      build_exp(32'h2038, 0, 3);
      send_req(32'h2038, 3'd2, 8'd3, 1, 16'h1234, 4'h5, 6'h2A, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL cross_accept: req_ready never high"); return; end
      collect(4, 0, 0, 0);
      checks++;
      if (timed_out || obs_id.size() != 4) begin failures++; $display("FAIL cross_count: got %0d want 4", obs_id.size()); return; end
      checks++;
      if (ar_q.size() != 2 || ar_q[0] !== 32'h2000 || ar_q[1] !== 32'h2040)
         begin failures++; $display("FAIL cross_ar: n=%0d want 00002000,00002040", ar_q.size()); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (obs_data[k] !== exp_w[k] || obs_id[k] !== 8'(k) || obs_last[k] !== (k == 3))
            begin failures++; $display("FAIL cross_word%0d: data %h id %0d last %b want %h %0d %b", k, obs_data[k], obs_id[k], obs_last[k], exp_w[k], k, k == 3); end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [31:0] a;
      a = $urandom;
      mem_rand = 0; ar_stall_cfg = 0; r_lat_cfg = 0;
      build_exp(a, 1, 7);
      send_req(a, 3'd3, 8'd7, 1, 16'h0BAD, 4'h1, 6'h05, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL bp_accept: req_ready never high"); return; end
      collect(8, 2, 5, 0);
      checks++;
      if (timed_out || obs_id.size() != 8) begin failures++; $display("FAIL bp_count: got %0d want 8", obs_id.size()); return; end
      checks++;
      if (hold_viol != 0) begin failures++; $display("FAIL bp_stable: %0d payload changes while stalled, want 0", hold_viol); end
      checks++;
      if (rr_viol != 0) begin failures++; $display("FAIL bp_req_ready: high %0d cycles mid-request, want 0", rr_viol); end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (obs_data[k] !== exp_w[k] || obs_id[k] !== 8'(k) || obs_last[k] !== (k == 7))
            begin failures++; $display("FAIL bp_word%0d: data %h id %0d last %b want %h %0d %b", k, obs_data[k], obs_id[k], obs_last[k], exp_w[k], k, k == 7); end
      end
   endtask

   task automatic test_ar_stall();
      bit ok;
      logic [31:0] a;
      int lasts;
      a = $urandom;
      mem_rand = 0; ar_stall_cfg = 4; r_lat_cfg = 0; ar_unstable = 0;
      build_exp(a, 1, 7);
      send_req(a, 3'd7, 8'd7, 0, 16'h7777, 4'h9, 6'h3F, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL arst_accept: req_ready never high"); return; end
      collect(8, 0, 0, 0);
      ar_stall_cfg = 0;
      checks++;
      if (timed_out || obs_id.size() != 8) begin failures++; $display("FAIL arst_count: got %0d want 8", obs_id.size()); return; end
      checks++;
      if (ar_unstable != 0) begin failures++; $display("FAIL arst_addr_stable: %0d changes, want 0", ar_unstable); end
      lasts = 0;
      foreach (obs_last[k]) if (obs_last[k]) lasts++;
      checks++;
      if (lasts != 0) begin failures++; $display("FAIL arst_no_last: got %0d lasts want 0", lasts); end
      checks++;
      if (ar_q.size() != exp_ar_q.size()) begin failures++; $display("FAIL arst_ar_count: got %0d want %0d", ar_q.size(), exp_ar_q.size()); end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (obs_data[k] !== exp_w[k] || obs_id[k] !== 8'(k))
            begin failures++; $display("FAIL arst_word%0d: data %h id %0d want %h %0d", k, obs_data[k], obs_id[k], exp_w[k], k); end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int n;
      mem_rand = 0; ar_stall_cfg = 0; r_lat_cfg = 0;
      send_req(32'h3000, 3'd3, 8'd3, 1, 16'h4444, 4'h4, 6'h04, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rmid_accept: req_ready never high"); return; end
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         n++;
         bus.resp_ready = 1'b1;
         if (bus.resp_valid && bus.resp_word_id == 8'd1) break;
      end
      @(posedge clk);
      #2 rstn = 1'b0;
      bus.resp_ready = 1'b0;
      #1;
      checks++;
      if ({bus.req_ready, bus.mem_arvalid, bus.mem_rready, bus.resp_valid, bus.resp_last} !== 5'b0 ||
          {bus.mem_araddr, bus.resp_word_id, bus.resp_data} !== '0)
         begin failures++; $display("FAIL rmid_async: ctrl %b araddr %h id %h data %h want all 0", {bus.req_ready, bus.mem_arvalid, bus.mem_rready, bus.resp_valid, bus.resp_last}, bus.mem_araddr, bus.resp_word_id, bus.resp_data); end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready: got %b want 1", bus.req_ready); end
      build_exp(32'h3010, 1, 3);
      send_req(32'h3010, 3'd3, 8'd3, 1, 16'h5555, 4'h5, 6'h05, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rmid_accept2: req_ready never high"); return; end
      collect(4, 0, 0, 0);
      checks++;
      if (timed_out || obs_id.size() != 4) begin failures++; $display("FAIL rmid_count: got %0d want 4", obs_id.size()); return; end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (obs_data[k] !== exp_w[k] || obs_id[k] !== 8'(k) || obs_last[k] !== (k == 3))
            begin failures++; $display("FAIL rmid_word%0d: data %h id %0d last %b want %h %0d %b", k, obs_data[k], obs_id[k], obs_last[k], exp_w[k], k, k == 3); end
      end
   endtask

   task automatic test_random();
      bit ok, s8, mk;
      logic [31:0] a;
      logic [2:0] sz;
      int ln;
      task_t tk;
      subtype_t st;
      cq_slice_slot_t cq;
      mem_rand = 1;
      for (int i = 0; i < 25; i++) begin
         a = (i == 0) ? 32'hFFFF_FFF4 : $urandom;
         sz = 3'($urandom_range(0, 7));
         if (i % 2 == 0) sz = 3'd2;
         s8 = (sz != 3'd2);
         ln = $urandom_range(0, 15);
         mk = 1'($urandom_range(0, 1));
         tk = 16'($urandom); st = 4'($urandom); cq = 6'($urandom);
         build_exp(a, s8, ln);
         send_req(a, sz, 8'(ln), mk, tk, st, cq, ok);
         checks++;
         if (!ok) begin failures++; $display("FAIL rnd%0d_accept: req_ready never high", i); continue; end
         collect(ln + 1, 0, 0, 1);
         checks++;
         if (timed_out || obs_id.size() != ln + 1) begin failures++; $display("FAIL rnd%0d_count: got %0d want %0d", i, obs_id.size(), ln + 1); continue; end
         checks++;
         if (hold_viol != 0 || rr_viol != 0) begin failures++; $display("FAIL rnd%0d_hold: hold %0d ready %0d want 0 0", i, hold_viol, rr_viol); end
         checks++;
         if (ar_q != exp_ar_q) begin failures++; $display("FAIL rnd%0d_ar: got %0d lines want %0d", i, ar_q.size(), exp_ar_q.size()); end
         for (int k = 0; k <= ln; k++) begin
            checks++;
            if (obs_data[k] !== exp_w[k] || obs_id[k] !== 8'(k) || obs_last[k] !== (mk && k == ln) ||
                obs_task[k] !== tk || obs_sub[k] !== st || obs_cq[k] !== cq)
               begin failures++; $display("FAIL rnd%0d_word%0d: data %h id %0d last %b want %h %0d %b", i, k, obs_data[k], obs_id[k], obs_last[k], exp_w[k], k, mk && k == ln); end
         end
      end
      mem_rand = 0;
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_line_cross();
      test_backpressure();
      test_ar_stall();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
